// File: rtl/operand_sequencer.sv
// Collects two operands from the slide switches on debounced button presses and
// presents them as a valid/ready pair to a downstream subtractor.
module operand_sequencer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [1:0]       state_led
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'b01,
    LOAD_B  = 2'b10,
    PRESENT = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic             meta, sync;
  logic             deb, deb_d, press;
  logic [CNT_W-1:0] cnt;

  // Stage 1: two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= btn_load;
      sync <= meta;
    end
  end

  // Stage 2: debounce -- level changes only after DEBOUNCE_CYCLES disagreeing edges
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (sync == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      deb <= sync;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Stage 3: single-cycle pulse on the rising debounced level only
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_d <= 1'b0;
      press <= 1'b0;
    end else begin
      deb_d <= deb;
      press <= deb & ~deb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD_A;
    else       state <= state_nxt;
  end

  // A press in PRESENT is dropped; the transfer takes priority.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_A:  if (press)    state_nxt = LOAD_B;
      LOAD_B:  if (press)    state_nxt = PRESENT;
      PRESENT: if (op_ready) state_nxt = LOAD_A;
      default:               state_nxt = LOAD_A;
    endcase
  end

  always_comb begin
    state_led = state;
    op_valid  = (state == PRESENT);
  end

  // Operands are captured from sw at the consuming edge and held across transfers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a <= '0;
      op_b <= '0;
    end else begin
      if (state == LOAD_A && press) op_a <= sw;
      if (state == LOAD_B && press) op_b <= sw;
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer (WIDTH=8, DEBOUNCE_CYCLES=4) using a
// scoreboard of expected operand pairs checked at each handshake.
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       btn_load = 1'b0;
  logic       op_ready = 1'b0;
  logic [7:0] op_a, op_b;
  logic       op_valid;
  logic [1:0] state_led;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] sb_q[$];

  operand_sequencer #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .sw(sw), .btn_load(btn_load),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .state_led(state_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_btn(input logic [7:0] val, input int hold, input int rel);
    sw = val;
    btn_load = 1'b1;
    cycles(hold);
    btn_load = 1'b0;
    cycles(rel);
  endtask

  task automatic handshake();
    op_ready = 1'b1;
    cycles(1);
    op_ready = 1'b0;
  endtask

  // Scoreboard: a transfer happens at the next rising edge when valid && ready
  always @(negedge clk) begin
    #1;
    if (!reset && op_valid && op_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", sb_q.size(), 1);
      end else begin
        logic [15:0] e;
        e = sb_q.pop_front();
        check("sb_op_a", op_a, e[15:8]);
        check("sb_op_b", op_b, e[7:0]);
      end
    end
  end

  initial begin
    cycles(3);
    check("rst_op_a", op_a, 8'h00);
    check("rst_op_b", op_b, 8'h00);
    check("rst_valid", op_valid, 1'b0);
    check("rst_led", state_led, 2'b01);
    reset = 1'b0;
    cycles(2);

    // Short glitch must not register a press
    push_btn(8'h99, 3, 10);
    check("glitch_led", state_led, 2'b01);
    check("glitch_op_a", op_a, 8'h00);

    // Basic two-operand load
    push_btn(8'h2D, 10, 10);
    check("load_a_led", state_led, 2'b10);
    check("load_a_val", op_a, 8'h2D);
    push_btn(8'h17, 10, 10);
    check("pair_op_a", op_a, 8'h2D);
    check("pair_op_b", op_b, 8'h17);
    check("pair_valid", op_valid, 1'b1);
    check("pair_led", state_led, 2'b11);

    // Press while presenting is dropped; ready held low meanwhile
    push_btn(8'hFF, 10, 10);
    check("drop_op_a", op_a, 8'h2D);
    check("drop_op_b", op_b, 8'h17);
    check("drop_valid", op_valid, 1'b1);
    check("drop_led", state_led, 2'b11);
    sb_q.push_back({8'h2D, 8'h17});
    handshake();
    check("xfer_valid", op_valid, 1'b0);
    check("xfer_led", state_led, 2'b01);
    check("xfer_hold_a", op_a, 8'h2D);
    check("xfer_hold_b", op_b, 8'h17);

    // Ready while idle is ignored
    op_ready = 1'b1;
    cycles(3);
    op_ready = 1'b0;
    check("idle_ready_led", state_led, 2'b01);

    // Latency: first sampled at edge j, op_a updates after edge j+7 only
    sw = 8'h5A;
    btn_load = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("lat_before", op_a, 8'h2D);
    end
    @(negedge clk);
    check("lat_at", op_a, 8'h5A);
    check("lat_led", state_led, 2'b10);
    cycles(4);
    btn_load = 1'b0;
    cycles(10);
    check("lat_single", state_led, 2'b10);

    // Reset in LOAD_B
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("rstb_op_a", op_a, 8'h00);
    check("rstb_op_b", op_b, 8'h00);
    check("rstb_valid", op_valid, 1'b0);
    check("rstb_led", state_led, 2'b01);

    // Reset overrides a handshake in PRESENT
    push_btn(8'h33, 10, 10);
    push_btn(8'h44, 10, 10);
    check("pre_rst_led", state_led, 2'b11);
    reset = 1'b1;
    op_ready = 1'b1;
    cycles(1);
    reset = 1'b0;
    op_ready = 1'b0;
    check("rstp_valid", op_valid, 1'b0);
    check("rstp_op_a", op_a, 8'h00);
    check("rstp_led", state_led, 2'b01);

    // sw changes during debounce: value at the consume edge wins
    sw = 8'h11;
    btn_load = 1'b1;
    cycles(3);
    sw = 8'h22;
    cycles(7);
    btn_load = 1'b0;
    cycles(10);
    check("late_sw", op_a, 8'h22);

    // Button held through reset release yields exactly one press
    reset = 1'b1;
    sw = 8'h66;
    btn_load = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(30);
    btn_load = 1'b0;
    cycles(10);
    check("held_op_a", op_a, 8'h66);
    check("held_led", state_led, 2'b10);
    push_btn(8'h77, 10, 10);
    check("held_pair_valid", op_valid, 1'b1);
    sb_q.push_back({8'h66, 8'h77});
    handshake();
    check("final_led", state_led, 2'b01);
    cycles(2);
    check("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
